// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter: shares single-ported main RAM between fetch and data ports.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ram_ready
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IACC = 2'd1,
    S_DACC = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_store;
  logic              r_wflag;

  logic w_dreq;
  logic w_grant_d;
  logic w_grant_i;
  logic w_idone;
  logic w_ddone;

  assign w_dreq  = dREN | dWEN;
  assign w_idone = (r_state == S_IACC) && ram_ready;
  assign w_ddone = (r_state == S_DACC) && ram_ready;

  assign ramaddr  = r_addr;
  assign ramstore = r_store;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_d   = 1'b0;
    w_grant_i   = 1'b0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    iwait       = iREN & ~w_idone;
    dwait       = w_dreq & ~w_ddone;
    iload       = '0;
    dload       = '0;

    case (r_state)
      S_IDLE: begin
        // A lone data request wins even once the starvation limit is reached.
        if (w_dreq && ((r_starve_cnt < c_starve_max) || !iREN)) begin
          w_grant_d   = 1'b1;
          w_state_nxt = S_DACC;
        end else if (iREN) begin
          w_grant_i   = 1'b1;
          w_state_nxt = S_IACC;
        end
      end
      S_IACC: begin
        ramREN = 1'b1;
        if (ram_ready) w_state_nxt = S_IDLE;
      end
      S_DACC: begin
        ramREN = ~r_wflag;
        ramWEN = r_wflag;
        if (ram_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Responses to withdrawn requests are discarded.
    if (w_idone && iREN) iload = ramload;
    if (w_ddone && dREN && !r_wflag) dload = ramload;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_addr       <= '0;
      r_store      <= '0;
      r_wflag      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_d) begin
        r_addr  <= daddr;
        r_store <= dstore;
        r_wflag <= dWEN;
        if (!iREN) begin
          r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_starve_max) begin
          r_starve_cnt <= r_starve_cnt + c_cnt_one;
        end
      end
      if (w_grant_i) begin
        r_addr       <= iaddr;
        r_starve_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter: directed self-checking bench for mem_arbiter.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(32), .WORD_W(32), .STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 0 = no strobe, 1 = fetch read of 0x44, 2 = data read of 0x104, 3 = other
  function automatic logic [31:0] kind();
    if (ramWEN) return 32'd3;
    if (!ramREN) return 32'd0;
    if (ramaddr == 32'h104) return 32'd2;
    if (ramaddr == 32'h44) return 32'd1;
    return 32'd3;
  endfunction

  initial begin
    logic [31:0] exp_kind;

    RST = 1'b1; iREN = 1'b1; iaddr = 32'h40;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    ramload = '0; ram_ready = 1'b0;

    // Reset held for two edges with a fetch pending
    tick(); tick();
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_dwait", {31'd0, dwait}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_iload", iload, 32'h0);
    RST = 1'b0;

    // Single fetch: IACC on first edge after release
    tick();
    chk("fetch_ramREN", {31'd0, ramREN}, 32'd1);
    chk("fetch_ramaddr", ramaddr, 32'h40);
    chk("fetch_iwait_pre", {31'd0, iwait}, 32'd1);
    iaddr = 32'h99; ram_ready = 1'b1; ramload = 32'hDEADBEEF;
    #1;
    chk("fetch_iwait_low", {31'd0, iwait}, 32'd0);
    chk("fetch_iload", iload, 32'hDEADBEEF);
    chk("fetch_ramaddr_hold", ramaddr, 32'h40);
    tick();
    ram_ready = 1'b0;
    #1;
    chk("fetch_idle_ramREN", {31'd0, ramREN}, 32'd0);
    chk("fetch_iwait_back", {31'd0, iwait}, 32'd1);
    chk("fetch_idle_iload", iload, 32'h0);
    iREN = 1'b0;
    tick();

    // Priority: data and fetch together, data first
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100;
    tick();
    chk("prio_ramREN", {31'd0, ramREN}, 32'd1);
    chk("prio_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("prio_ramaddr", ramaddr, 32'h100);
    chk("prio_dwait_pre", {31'd0, dwait}, 32'd1);
    ram_ready = 1'b1; ramload = 32'hCAFEF00D;
    #1;
    chk("prio_dwait_low", {31'd0, dwait}, 32'd0);
    chk("prio_dload", dload, 32'hCAFEF00D);
    chk("prio_iload_zero", iload, 32'h0);
    chk("prio_iwait", {31'd0, iwait}, 32'd1);
    tick();
    dREN = 1'b0; ram_ready = 1'b0;
    #1;
    chk("prio_gap_ramREN", {31'd0, ramREN}, 32'd0);
    tick();
    chk("prio_iacc_ramREN", {31'd0, ramREN}, 32'd1);
    chk("prio_iacc_ramaddr", ramaddr, 32'h80);
    ram_ready = 1'b1; ramload = 32'h11112222;
    #1;
    chk("prio_iload", iload, 32'h11112222);
    tick();
    iREN = 1'b0; ram_ready = 1'b0;

    // Write held for three cycles, daddr/dstore changed mid-access
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'h12345678;
    tick();
    chk("wr_ramWEN_c1", {31'd0, ramWEN}, 32'd1);
    chk("wr_ramREN_c1", {31'd0, ramREN}, 32'd0);
    chk("wr_ramaddr_c1", ramaddr, 32'h200);
    chk("wr_ramstore_c1", ramstore, 32'h12345678);
    chk("wr_dwait_c1", {31'd0, dwait}, 32'd1);
    daddr = 32'h300; dstore = 32'h0;
    tick();
    chk("wr_ramWEN_c2", {31'd0, ramWEN}, 32'd1);
    chk("wr_ramaddr_c2", ramaddr, 32'h200);
    chk("wr_ramstore_c2", ramstore, 32'h12345678);
    chk("wr_dwait_c2", {31'd0, dwait}, 32'd1);
    tick();
    ram_ready = 1'b1; ramload = 32'h77778888;
    #1;
    chk("wr_ramWEN_c3", {31'd0, ramWEN}, 32'd1);
    chk("wr_ramaddr_c3", ramaddr, 32'h200);
    chk("wr_dwait_c3", {31'd0, dwait}, 32'd0);
    chk("wr_dload_zero", dload, 32'h0);
    tick();
    dWEN = 1'b0; ram_ready = 1'b0;
    #1;
    chk("wr_idle_ramWEN", {31'd0, ramWEN}, 32'd0);

    // Starvation: 4 data grants, 1 fetch, 4 data, 1 fetch
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h104;
    ram_ready = 1'b1; ramload = 32'h5555AAAA;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c % 2 == 0) exp_kind = 32'd0;
      else if (c == 9 || c == 19) exp_kind = 32'd1;
      else exp_kind = 32'd2;
      chk($sformatf("starve_c%0d", c), kind(), exp_kind);
    end
    iREN = 1'b0; dREN = 1'b0; ram_ready = 1'b0;

    // ram_ready in IDLE is ignored
    tick();
    ram_ready = 1'b1;
    #1;
    chk("idle_rdy_iload", iload, 32'h0);
    chk("idle_rdy_dload", dload, 32'h0);
    tick();
    chk("idle_rdy_ramREN", {31'd0, ramREN}, 32'd0);
    ram_ready = 1'b0;

    // Fetch withdrawn during IACC
    iREN = 1'b1; iaddr = 32'h48;
    tick();
    iREN = 1'b0;
    #1;
    chk("wd_ramREN", {31'd0, ramREN}, 32'd1);
    chk("wd_iwait", {31'd0, iwait}, 32'd0);
    tick();
    chk("wd_ramREN_hold", {31'd0, ramREN}, 32'd1);
    ram_ready = 1'b1; ramload = 32'hAAAA5555;
    #1;
    chk("wd_iload_zero", iload, 32'h0);
    chk("wd_iwait_done", {31'd0, iwait}, 32'd0);
    tick();
    ram_ready = 1'b0;
    #1;
    chk("wd_idle_ramREN", {31'd0, ramREN}, 32'd0);

    // Reset during a data write
    dWEN = 1'b1; daddr = 32'h208; dstore = 32'h5A;
    tick();
    chk("rstd_ramWEN_pre", {31'd0, ramWEN}, 32'd1);
    RST = 1'b1;
    tick();
    chk("rstd_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rstd_ramaddr", ramaddr, 32'h0);
    chk("rstd_dwait", {31'd0, dwait}, 32'd1);
    RST = 1'b0; dWEN = 1'b0;
    tick();
    chk("rstd_idle_ramREN", {31'd0, ramREN}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
